// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, FSM states and baud divider helper
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } uart_tx_state_t;

    // Clock cycles per bit, rounded to nearest.
    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - write port and line-side status of the buffered UART transmitter
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16
);
    logic                         in_valid;
    logic [DATA_BITS-1:0]         in_data;
    logic                         in_ready;
    logic [$clog2(DEPTH+1)-1:0]   level;
    logic                         busy;
    logic                         tx;

    modport master (
        output in_valid, in_data,
        input  in_ready, level, busy, tx
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, level, busy, tx
    );
endinterface

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous show-ahead FIFO with wrap-bit pointers
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("uart_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // A full FIFO refuses a write even when a pop happens in the same cycle.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign level = r_wr_ptr - r_rd_ptr;
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; reset discards the contents by equalising the pointers.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter: FIFO, bit timer, framing FSM
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int      CLK_HZ    = 50_000_000,
    parameter int      BAUD      = 115_200,
    parameter int      DATA_BITS = 8,
    parameter parity_t PARITY    = NONE,
    parameter int      STOP_BITS = 1,
    parameter int      DEPTH     = 16
) (
    input  logic             clk,
    input  logic             rst_,
    uart_tx_fifo_if.slave    bus
);

    localparam int DIV = uart_div(CLK_HZ, BAUD);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = $clog2(DATA_BITS);

    if (DIV < 2) begin : g_div_chk
        $error("uart_tx_fifo: clock cycles per bit must be at least 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bits_chk
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_stop_chk
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end

    uart_tx_state_t       r_state;
    logic [TW-1:0]        r_timer;
    logic [BW-1:0]        r_bit_idx;
    logic                 r_stop_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;
    logic                 r_busy;

    logic                 w_full;
    logic                 w_empty;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_bit_end;
    logic                 w_last_stop;
    logic                 w_pop;
    logic                 w_par_bit;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_  (rst_),
        .push  (bus.in_valid),
        .pop   (w_pop),
        .din   (bus.in_data),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (bus.level)
    );

    assign bus.in_ready = !w_full;
    assign bus.tx       = r_tx;
    assign bus.busy     = r_busy;

    assign w_bit_end   = (r_timer == TW'(DIV - 1));
    assign w_last_stop = (r_state == STOP) && w_bit_end &&
                         (r_stop_cnt == 1'(STOP_BITS - 1));
    // Pop from IDLE, or at the last stop cycle so the next start bit follows without a gap.
    assign w_pop       = !w_empty && ((r_state == IDLE) || w_last_stop);
    assign w_par_bit   = (PARITY == ODD) ? ~(^w_head) : (^w_head);

    // Framing FSM with bit timer, bit/stop counters and registered line outputs.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            if (r_state != IDLE) begin
                r_timer <= w_bit_end ? '0 : r_timer + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_shift <= w_head;
                        r_par   <= w_par_bit;
                        r_timer <= '0;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == BW'(DATA_BITS - 1)) begin
                            r_stop_cnt <= 1'b0;
                            if (PARITY != NONE) begin
                                r_tx    <= r_par;
                                r_state <= PAR;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                PAR: begin
                    if (w_bit_end) begin
                        r_stop_cnt <= 1'b0;
                        r_tx       <= 1'b1;
                        r_state    <= STOP;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
                            if (!w_empty) begin
                                r_shift <= w_head;
                                r_par   <= w_par_bit;
                                r_tx    <= 1'b0;
                                r_state <= START;
                            end else begin
                                r_tx    <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= IDLE;
                            end
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
